// File: rtl/sparse_mac_pe_if.sv
// Operand, weight and result signals of one sparse MAC processing element.
// The master drives operands/weights and observes the PE outputs; the PE is the slave.
interface sparse_mac_pe_if #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
);
    logic             weight_load;
    logic [DW-1:0]    weight_in;
    logic             weight_swap;
    logic             in_valid;
    logic [DW-1:0]    in_value;
    logic [DW-1:0]    in_accumulate;
    logic             stall;
    logic             out_valid;
    logic [DW-1:0]    out_accumulate;
    logic [DW-1:0]    out_value;
    logic             out_value_valid;
    logic [CNT_W-1:0] skip_count;
    logic             busy;

    modport master (
        output weight_load, weight_in, weight_swap, in_valid, in_value,
               in_accumulate, stall,
        input  out_valid, out_accumulate, out_value, out_value_valid,
               skip_count, busy
    );

    modport slave (
        input  weight_load, weight_in, weight_swap, in_valid, in_value,
               in_accumulate, stall,
        output out_valid, out_accumulate, out_value, out_value_valid,
               skip_count, busy
    );
endinterface

// File: rtl/sparse_mac_pe.sv
// Weight-stationary multiply-accumulate PE with zero-skip bypass, stall freeze and
// double-buffered weights; optional saturating accumulate.
module sparse_mac_pe #(
    parameter int DW         = 16,
    parameter int MUL_STAGES = 2,
    parameter int SATURATE   = 0,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    sparse_mac_pe_if.slave pe
);

    logic [DW-1:0]         w_shadow_r;
    logic [DW-1:0]         w_active_r;
    logic [MUL_STAGES-1:0] vld_r;
    logic [MUL_STAGES-1:0] skp_r;
    logic [DW-1:0]         prod_r [MUL_STAGES];
    logic [DW-1:0]         acc_r  [MUL_STAGES];
    logic                  out_valid_r;
    logic [DW-1:0]         out_acc_r;
    logic                  out_value_valid_r;
    logic [DW-1:0]         out_value_r;
    logic [CNT_W-1:0]      skip_count_r;

    logic                  accept_s;
    logic                  skip_s;
    logic [2*DW-1:0]       full_prod_s;
    logic [DW-1:0]         mul_s;
    logic [DW-1:0]         last_prod_s;
    logic [DW-1:0]         sum_s;

    // Add at DW+1 bits so the carry-out exposes signed overflow for clamping.
    function automatic logic [DW-1:0] acc_add(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic          sat);
        logic [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (sat && (s[DW] != s[DW-1])) begin
            return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            return s[DW-1:0];
        end
    endfunction

    // Acceptance, zero detection, multiply and final accumulate.
    always_comb begin
        accept_s    = pe.in_valid && !pe.stall;
        skip_s      = (pe.in_value == {DW{1'b0}}) || (w_active_r == {DW{1'b0}});
        full_prod_s = $signed(pe.in_value) * $signed(w_active_r);
        mul_s       = full_prod_s[DW-1:0];
        if (skp_r[MUL_STAGES-1]) begin
            last_prod_s = {DW{1'b0}};
        end else begin
            last_prod_s = prod_r[MUL_STAGES-1];
        end
        sum_s = acc_add(last_prod_s, acc_r[MUL_STAGES-1], SATURATE != 0);
    end

    // Multiplier pipeline; product registers of skipped beats keep their old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {MUL_STAGES{1'b0}};
            skp_r <= {MUL_STAGES{1'b0}};
            for (int k = 0; k < MUL_STAGES; k++) begin
                prod_r[k] <= {DW{1'b0}};
                acc_r[k]  <= {DW{1'b0}};
            end
        end else if (!pe.stall) begin
            vld_r[0] <= pe.in_valid;
            skp_r[0] <= skip_s;
            acc_r[0] <= pe.in_accumulate;
            if (pe.in_valid && !skip_s) begin
                prod_r[0] <= mul_s;
            end
            for (int k = 1; k < MUL_STAGES; k++) begin
                vld_r[k] <= vld_r[k-1];
                skp_r[k] <= skp_r[k-1];
                acc_r[k] <= acc_r[k-1];
                if (vld_r[k-1] && !skp_r[k-1]) begin
                    prod_r[k] <= prod_r[k-1];
                end
            end
        end
    end

    // Output stage: result register plus the forwarded activation.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r       <= 1'b0;
            out_acc_r         <= {DW{1'b0}};
            out_value_valid_r <= 1'b0;
            out_value_r       <= {DW{1'b0}};
        end else if (!pe.stall) begin
            out_valid_r       <= vld_r[MUL_STAGES-1];
            if (vld_r[MUL_STAGES-1]) begin
                out_acc_r <= sum_s;
            end
            out_value_valid_r <= pe.in_valid;
            if (pe.in_valid) begin
                out_value_r <= pe.in_value;
            end
        end
    end

    // Weight double buffer runs regardless of stall; a simultaneous load+swap
    // promotes the old shadow value.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_shadow_r <= {DW{1'b0}};
            w_active_r <= {DW{1'b0}};
        end else begin
            if (pe.weight_load) begin
                w_shadow_r <= pe.weight_in;
            end
            if (pe.weight_swap) begin
                w_active_r <= w_shadow_r;
            end
        end
    end

    // Saturating count of accepted zero-skip beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_count_r <= {CNT_W{1'b0}};
        end else if (accept_s && skip_s && (skip_count_r != {CNT_W{1'b1}})) begin
            skip_count_r <= skip_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign pe.out_valid       = out_valid_r;
    assign pe.out_accumulate  = out_acc_r;
    assign pe.out_value_valid = out_value_valid_r;
    assign pe.out_value       = out_value_r;
    assign pe.skip_count      = skip_count_r;
    assign pe.busy            = (|vld_r) || out_valid_r;

endmodule

// File: tb/tb_sparse_mac_pe.sv
// Scoreboard bench for sparse_mac_pe: a wrapping and a saturating instance share
// stimulus; expected sums are queued at acceptance and retired when due.
module tb_sparse_mac_pe;
    localparam int DW = 16;
    localparam int MS = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sparse_mac_pe_if #(.DW(DW), .CNT_W(CW)) if0 ();
    sparse_mac_pe_if #(.DW(DW), .CNT_W(CW)) if1 ();

    assign if1.weight_load   = if0.weight_load;
    assign if1.weight_in     = if0.weight_in;
    assign if1.weight_swap   = if0.weight_swap;
    assign if1.in_valid      = if0.in_valid;
    assign if1.in_value      = if0.in_value;
    assign if1.in_accumulate = if0.in_accumulate;
    assign if1.stall         = if0.stall;

    sparse_mac_pe #(.DW(DW), .MUL_STAGES(MS), .SATURATE(0), .CNT_W(CW)) dut_wrap (
        .clk(clk), .rst(rst), .pe(if0.slave));
    sparse_mac_pe #(.DW(DW), .MUL_STAGES(MS), .SATURATE(1), .CNT_W(CW)) dut_sat (
        .clk(clk), .rst(rst), .pe(if1.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] r_wrap;
        logic [DW-1:0] r_sat;
        int            rem;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] m_shadow = '0, m_active = '0;
    logic [DW-1:0] m_oa_wrap = '0, m_oa_sat = '0, m_oval = '0;
    logic          m_ov = 1'b0, m_ovv = 1'b0;
    logic [CW-1:0] m_skip = '0;

    // Drive one cycle, advance the model at the edge, check at the falling edge.
    task automatic step(input logic v, input logic [DW-1:0] val, input logic [DW-1:0] acc,
                        input logic stl = 1'b0, input logic wl = 1'b0,
                        input logic [DW-1:0] win = '0, input logic ws = 1'b0,
                        input logic r = 1'b0);
        logic signed [31:0]   p;
        logic signed [DW-1:0] ps, as;
        int                   s;
        bit                   upd, skip;
        exp_t                 e;
        rst = r;
        if0.in_valid = v; if0.in_value = val; if0.in_accumulate = acc;
        if0.stall = stl; if0.weight_load = wl; if0.weight_in = win; if0.weight_swap = ws;
        @(posedge clk);
        upd = 1'b0;
        if (r) begin
            sb.delete();
            m_shadow = '0; m_active = '0; m_skip = '0;
            m_ov = 1'b0; m_oa_wrap = '0; m_oa_sat = '0; m_ovv = 1'b0; m_oval = '0;
        end else begin
            if (!stl) begin
                upd = 1'b1;
                foreach (sb[i]) sb[i].rem--;
                if (v) begin
                    skip = (val == 16'h0000) || (m_active == 16'h0000);
                    p  = $signed(val) * $signed(m_active);
                    ps = skip ? 16'sh0000 : p[DW-1:0];
                    as = acc;
                    s  = int'(ps) + int'(as);
                    e.r_wrap = s[DW-1:0];
                    if (s > 32767)       e.r_sat = 16'h7FFF;
                    else if (s < -32768) e.r_sat = 16'h8000;
                    else                 e.r_sat = s[DW-1:0];
                    e.rem = MS;
                    sb.push_back(e);
                    if (skip && m_skip != 4'hF) m_skip = m_skip + 4'd1;
                    m_oval = val;
                end
                m_ovv = v;
            end
            if (ws) m_active = m_shadow;
            if (wl) m_shadow = win;
        end
        @(negedge clk);
        if (upd) begin
            if (sb.size() > 0 && sb[0].rem == 0) begin
                e = sb.pop_front();
                m_ov = 1'b1; m_oa_wrap = e.r_wrap; m_oa_sat = e.r_sat;
            end else begin
                m_ov = 1'b0;
            end
        end
        check_eq("out_valid_wrap", {31'd0, if0.out_valid}, {31'd0, m_ov});
        check_eq("out_valid_sat", {31'd0, if1.out_valid}, {31'd0, m_ov});
        check_eq("out_acc_wrap", {16'd0, if0.out_accumulate}, {16'd0, m_oa_wrap});
        check_eq("out_acc_sat", {16'd0, if1.out_accumulate}, {16'd0, m_oa_sat});
        check_eq("skip_count", {28'd0, if0.skip_count}, {28'd0, m_skip});
        check_eq("out_value_valid", {31'd0, if0.out_value_valid}, {31'd0, m_ovv});
        check_eq("out_value", {16'd0, if0.out_value}, {16'd0, m_oval});
        check_eq("busy", {31'd0, if0.busy}, {31'd0, (sb.size() > 0) || m_ov});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        step(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b1, 16'h0009, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        // Basic MAC: 5*3+10 = 25
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0003);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h0005, 16'h000A);
        idle(4);
        // Zero-skip by operand, then by weight
        step(1'b1, 16'h0000, 16'h1234);
        idle(4);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h0007, 16'h0042);
        idle(4);
        // Overflow in both directions
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h7FFF, 16'h0001);
        step(1'b1, 16'h8000, 16'hFFFF);
        idle(4);
        // Stall of two cycles with ignored in_valid: 4*2+1 = 9
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0002);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h0004, 16'h0001);
        step(1'b1, 16'h0063, 16'h0063, 1'b1);
        step(1'b1, 16'h0064, 16'h0064, 1'b1);
        idle(5);
        // Load+swap on one edge, then swap between back-to-back beats: 6 then 15
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0002);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1);
        step(1'b1, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h0003, 16'h0000);
        idle(4);
        // Reset with beats in flight: nothing emitted afterwards
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0004);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h0002, 16'h0001);
        step(1'b1, 16'h0000, 16'h0001);
        step(1'b1, 16'h0003, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        idle(5);
        // Skip counter saturation (weight is zero after reset)
        for (int i = 0; i < 20; i++) step(1'b1, 16'h0001, 16'(i));
        idle(4);
        // Random traffic with stalls, weight activity and rare resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom),
                 16'($urandom),
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0,
                 ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 99) == 0);
        end
        idle(6);
        check_eq("drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
